// File: rtl/serial_to_parallel_converter_pkg.sv
// ---------------------------------------------------------------------------
// serial_to_parallel_converter_pkg
//   Shared definitions for the serial converters (transmit and receive side).
//   shift_direction_t selects the bit order of a serial word:
//     MSB_FIRST : first bit on the wire is bit N-1 of the word
//     LSB_FIRST : first bit on the wire is bit 0 of the word
// ---------------------------------------------------------------------------
package serial_to_parallel_converter_pkg;

    typedef enum logic [0:0] {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } shift_direction_t;

endpackage

// File: rtl/serial_to_parallel_converter_bit_counter.sv
// ---------------------------------------------------------------------------
// serial_to_parallel_converter_bit_counter
//   Mod-N bit counter with enable, synchronous clear and a terminal-count
//   pulse. Reusable for bit sequencing on either side of a serial link.
//
//   Ports:
//     clk    in   system clock
//     rst    in   synchronous active-high reset
//     clear  in   synchronous clear to zero (lower priority than rst)
//     en     in   advance the count this cycle
//     count  out  current count, 0..N-1 (registered)
//     tc     out  en is high while count == N-1 (the count wraps to 0 on
//                 this edge)
// ---------------------------------------------------------------------------
module serial_to_parallel_converter_bit_counter
    import serial_to_parallel_converter_pkg::*;
#(
    parameter int N = 4,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc
);

    logic [CW-1:0] count_r;
    logic          last_s;

    // Terminal-count decode.
    always_comb begin
        last_s = (count_r == CW'(N - 1));
        tc     = en & last_s;
    end

    // Count register: wraps to zero after N-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= CW'(0);
        end else if (clear) begin
            count_r <= CW'(0);
        end else if (en) begin
            if (last_s) begin
                count_r <= CW'(0);
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/serial_to_parallel_converter.sv
// ---------------------------------------------------------------------------
// serial_to_parallel_converter
//   Collects a serial bit stream into N-bit words (MSB_FIRST or LSB_FIRST)
//   and presents each completed word on a valid/ready port. The serial side
//   cannot be stalled: a word completed while the previous one is still
//   pending and not being accepted is dropped and o_overrun is set (sticky).
//
//   Ports:
//     clk        in   system clock, all logic on posedge
//     rst        in   synchronous active-high reset
//     i_valid    in   i_bit holds a valid serial bit this cycle
//     i_bit      in   serial data bit
//     direction  in   bit order, sampled with the first bit of each word
//     i_clear    in   abort the partial word and clear o_overrun
//     i_ready    in   downstream accepts o_data this cycle
//     o_data     out  assembled word
//     o_valid    out  o_data holds an undelivered word
//     o_overrun  out  sticky: a completed word was dropped
//     o_count    out  bits collected in the current partial word (0..N-1)
// ---------------------------------------------------------------------------
module serial_to_parallel_converter
    import serial_to_parallel_converter_pkg::*;
#(
    parameter int N = 4,
    localparam int CW = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_bit,
    input  shift_direction_t direction,
    input  logic             i_clear,
    input  logic             i_ready,
    output logic [N-1:0]     o_data,
    output logic             o_valid,
    output logic             o_overrun,
    output logic [CW-1:0]    o_count
);

    logic [N-1:0]     sr_r;
    shift_direction_t dir_r;
    logic [N-1:0]     data_r;
    logic             valid_r;
    logic             overrun_r;

    logic [CW-1:0]    count_s;
    logic             capture_s;
    logic             complete_s;
    logic             first_bit_s;
    shift_direction_t dir_s;
    logic [N-1:0]     next_sr_s;
    logic             transfer_s;
    logic             can_load_s;

    // Shift one bit into the word in the selected order.
    function automatic logic [N-1:0] shift_in(
        input logic [N-1:0]     sr,
        input logic             b,
        input shift_direction_t d
    );
        case (d)
            MSB_FIRST: return {sr[N-2:0], b};
            LSB_FIRST: return {b, sr[N-1:1]};
            default:   return {sr[N-2:0], b};
        endcase
    endfunction

    serial_to_parallel_converter_bit_counter #(
        .N (N)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (i_clear),
        .en    (capture_s),
        .count (count_s),
        .tc    (complete_s)
    );

    // Capture qualification, bit-order selection and handshake decode.
    // The first bit of a word uses the live direction input; the rest of the
    // word uses the value latched with that first bit.
    always_comb begin
        capture_s   = i_valid & ~i_clear;
        first_bit_s = (count_s == CW'(0));
        if (first_bit_s) begin
            dir_s = direction;
        end else begin
            dir_s = dir_r;
        end
        next_sr_s   = shift_in(sr_r, i_bit, dir_s);
        transfer_s  = valid_r & i_ready;
        // A new word may load if the slot is empty or is being emptied now.
        can_load_s  = ~valid_r | i_ready;
    end

    // Shift register and latched bit order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r  <= {N{1'b0}};
            dir_r <= MSB_FIRST;
        end else if (i_clear) begin
            sr_r  <= {N{1'b0}};
            dir_r <= dir_r;
        end else if (i_valid) begin
            sr_r  <= next_sr_s;
            dir_r <= dir_s;
        end else begin
            sr_r  <= sr_r;
            dir_r <= dir_r;
        end
    end

    // Output word register and valid flag (i_clear leaves a pending word).
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= {N{1'b0}};
            valid_r <= 1'b0;
        end else if (complete_s && can_load_s) begin
            data_r  <= next_sr_s;
            valid_r <= 1'b1;
        end else if (transfer_s) begin
            data_r  <= data_r;
            valid_r <= 1'b0;
        end else begin
            data_r  <= data_r;
            valid_r <= valid_r;
        end
    end

    // Sticky overrun flag: set when a completed word finds the slot blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (i_clear) begin
            overrun_r <= 1'b0;
        end else if (complete_s && !can_load_s) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign o_data    = data_r;
    assign o_valid   = valid_r;
    assign o_overrun = overrun_r;
    assign o_count   = count_s;

endmodule

// File: tb/tb_serial_to_parallel_converter.sv
// ---------------------------------------------------------------------------
// tb_serial_to_parallel_converter
//   Directed bench for the N=4 serial-to-parallel converter. Inputs change
//   1 time unit after each rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_serial_to_parallel_converter;
    import serial_to_parallel_converter_pkg::*;

    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic             clk;
    logic             rst;
    logic             i_valid;
    logic             i_bit;
    shift_direction_t direction;
    logic             i_clear;
    logic             i_ready;
    logic [N-1:0]     o_data;
    logic             o_valid;
    logic             o_overrun;
    logic [CW-1:0]    o_count;

    int n_checks;
    int n_fail;

    serial_to_parallel_converter #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_bit     (i_bit),
        .direction (direction),
        .i_clear   (i_clear),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_overrun (o_overrun),
        .o_count   (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, wait for the edge, settle.
    task automatic cyc(input logic v, input logic b, input shift_direction_t d,
                       input logic clr, input logic rdy);
        i_valid   = v;
        i_bit     = b;
        direction = d;
        i_clear   = clr;
        i_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b1, MSB_FIRST, 1'b0, rdy);
    endtask

    // Send a 4-bit word MSB first; the last bit uses rdy_last.
    task automatic send_msb(input logic [3:0] w, input logic rdy, input logic rdy_last);
        for (int i = 3; i >= 1; i--) begin
            cyc(1'b1, w[i], MSB_FIRST, 1'b0, rdy);
        end
        cyc(1'b1, w[0], MSB_FIRST, 1'b0, rdy_last);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        i_valid   = 1'b0;
        i_bit     = 1'b0;
        direction = MSB_FIRST;
        i_clear   = 1'b0;
        i_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_data",    32'(o_data),    32'h0);
        chk("rst_valid",   32'(o_valid),   32'h0);
        chk("rst_overrun", 32'(o_overrun), 32'h0);
        chk("rst_count",   32'(o_count),   32'h0);

        // 1. MSB_FIRST 1,0,1,1 -> 4'b1011, count 1,2,3,0
        cyc(1'b1, 1'b1, MSB_FIRST, 1'b0, 1'b1);
        chk("t1_count1", 32'(o_count), 32'd1);
        cyc(1'b1, 1'b0, MSB_FIRST, 1'b0, 1'b1);
        chk("t1_count2", 32'(o_count), 32'd2);
        cyc(1'b1, 1'b1, MSB_FIRST, 1'b0, 1'b1);
        chk("t1_count3", 32'(o_count), 32'd3);
        chk("t1_valid_early", 32'(o_valid), 32'h0);
        cyc(1'b1, 1'b1, MSB_FIRST, 1'b0, 1'b1);
        chk("t1_count0", 32'(o_count), 32'd0);
        chk("t1_valid",  32'(o_valid), 32'h1);
        chk("t1_data",   32'(o_data),  32'hB);
        idle(1'b1);
        chk("t1_consumed_valid", 32'(o_valid), 32'h0);
        chk("t1_data_kept",      32'(o_data),  32'hB);

        // 2. LSB_FIRST 1,0,1,1 with gaps 0,2,1; direction toggled after bit 2
        cyc(1'b1, 1'b1, LSB_FIRST, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, LSB_FIRST, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("t2_gap_count", 32'(o_count), 32'd2);
        cyc(1'b1, 1'b1, MSB_FIRST, 1'b0, 1'b1);
        idle(1'b1);
        chk("t2_valid_early", 32'(o_valid), 32'h0);
        cyc(1'b1, 1'b1, MSB_FIRST, 1'b0, 1'b1);
        chk("t2_valid", 32'(o_valid), 32'h1);
        chk("t2_data",  32'(o_data),  32'hD);
        idle(1'b1);

        // 3. Back-to-back words 1100, 0101 with i_ready=1
        send_msb(4'b1100, 1'b1, 1'b1);
        chk("t3_w1_valid", 32'(o_valid), 32'h1);
        chk("t3_w1_data",  32'(o_data),  32'hC);
        chk("t3_w1_count", 32'(o_count), 32'd0);
        send_msb(4'b0101, 1'b1, 1'b1);
        chk("t3_w2_valid",   32'(o_valid),   32'h1);
        chk("t3_w2_data",    32'(o_data),    32'h5);
        chk("t3_w2_overrun", 32'(o_overrun), 32'h0);
        idle(1'b1);

        // 4a. Backpressure: A then B with i_ready=0 -> B dropped
        send_msb(4'hA, 1'b0, 1'b0);
        chk("t4_a_data", 32'(o_data), 32'hA);
        send_msb(4'h3, 1'b0, 1'b0);
        chk("t4_hold_data",  32'(o_data),    32'hA);
        chk("t4_hold_valid", 32'(o_valid),   32'h1);
        chk("t4_overrun",    32'(o_overrun), 32'h1);
        idle(1'b1);
        chk("t4_drain_valid",   32'(o_valid),   32'h0);
        chk("t4_sticky_overrun", 32'(o_overrun), 32'h1);
        cyc(1'b0, 1'b0, MSB_FIRST, 1'b1, 1'b0);
        chk("t4_clear_overrun", 32'(o_overrun), 32'h0);
        // 4b. i_ready=1 exactly on B's completion edge
        send_msb(4'hA, 1'b0, 1'b0);
        send_msb(4'h3, 1'b0, 1'b1);
        chk("t4b_data",    32'(o_data),    32'h3);
        chk("t4b_valid",   32'(o_valid),   32'h1);
        chk("t4b_overrun", 32'(o_overrun), 32'h0);
        idle(1'b1);

        // 5. Abort: build an overrun, then clear together with a 3rd bit
        send_msb(4'hF, 1'b0, 1'b0);
        send_msb(4'h0, 1'b0, 1'b0);
        idle(1'b1);
        chk("t5_pre_overrun", 32'(o_overrun), 32'h1);
        cyc(1'b1, 1'b1, MSB_FIRST, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, MSB_FIRST, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, MSB_FIRST, 1'b1, 1'b0);
        chk("t5_clear_count",   32'(o_count),   32'd0);
        chk("t5_clear_overrun", 32'(o_overrun), 32'h0);
        chk("t5_clear_valid",   32'(o_valid),   32'h0);
        cyc(1'b1, 1'b1, MSB_FIRST, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, MSB_FIRST, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, MSB_FIRST, 1'b0, 1'b0);
        chk("t5_no_early_word", 32'(o_valid), 32'h0);
        cyc(1'b1, 1'b1, MSB_FIRST, 1'b0, 1'b0);
        chk("t5_valid", 32'(o_valid), 32'h1);
        chk("t5_data",  32'(o_data),  32'h9);

        // 6. Reset with a pending word and 2 bits collected
        cyc(1'b1, 1'b1, MSB_FIRST, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, MSB_FIRST, 1'b0, 1'b0);
        chk("t6_pre_count", 32'(o_count), 32'd2);
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0;
        chk("t6_valid",   32'(o_valid),   32'h0);
        chk("t6_data",    32'(o_data),    32'h0);
        chk("t6_count",   32'(o_count),   32'h0);
        chk("t6_overrun", 32'(o_overrun), 32'h0);
        send_msb(4'b0110, 1'b0, 1'b0);
        chk("t6_word_valid", 32'(o_valid), 32'h1);
        chk("t6_word_data",  32'(o_data),  32'h6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
